// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG MCU/restart sequencer.
//   - Sequencer state encodings (legacy-compatible localparam constants)
//   - Component-index width
//   - Luma sampling-factor decode helper
package aq_djpeg_pkg;

  localparam int COMP_IDX_W = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_PREALIGN = 3'd2;
  localparam logic [2:0] ST_ALIGN    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Raw header code 0/1 means factor 1, 2/3 means factor 2.
  function automatic logic [2:0] sf_decode(input logic [1:0] sf);
    return sf[1] ? 3'd2 : 3'd1;
  endfunction

endpackage

// File: rtl/aq_djpeg_restart_ctrl.sv
// Restart-interval controller for the MCU sequencer.
// Counts completed MCUs against the restart interval and, at a boundary,
// runs the PREALIGN -> ALIGN handshake with the bitstream feeder.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   init              start of scan, clears all state
//   mcu_end           an MCU completes this cycle
//   last_mcu          the completing MCU is the last one of the scan
//   data_in_enable    feeder word valid (releases PREALIGN)
//   jpeg_restart      restart interval in MCUs, 0 disables restarts
//   reset_dc          DC predictors must be cleared (level, PREALIGN)
//   align_byte        one-cycle byte-alignment request (ALIGN)
//   rst_index         expected RSTn marker index, mod 8
//   gate              high when the decoder may consume data
module aq_djpeg_restart_ctrl
  import aq_djpeg_pkg::*;
#(
  parameter int RST_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             mcu_end,
  input  logic             last_mcu,
  input  logic             data_in_enable,
  input  logic [RST_W-1:0] jpeg_restart,
  output logic             reset_dc,
  output logic             align_byte,
  output logic [2:0]       rst_index,
  output logic             gate
);

  logic [2:0]       phase;
  logic [RST_W-1:0] rst_cnt;
  logic             boundary;

  assign boundary = (jpeg_restart != '0) && (rst_cnt + RST_W'(1) == jpeg_restart);
  assign gate     = (phase == ST_RUN);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || init) begin
      phase      <= ST_RUN;
      rst_cnt    <= '0;
      rst_index  <= '0;
      reset_dc   <= 1'b0;
      align_byte <= 1'b0;
    end else begin
      case (phase)
        ST_RUN: begin
          // The end of scan wins over a coincident restart boundary.
          if (mcu_end && !last_mcu) begin
            if (boundary) begin
              rst_cnt  <= '0;
              phase    <= ST_PREALIGN;
              reset_dc <= 1'b1;
            end else begin
              rst_cnt <= rst_cnt + RST_W'(1);
            end
          end
        end
        ST_PREALIGN: begin
          if (data_in_enable) begin
            phase      <= ST_ALIGN;
            reset_dc   <= 1'b0;
            align_byte <= 1'b1;
          end
        end
        ST_ALIGN: begin
          phase      <= ST_RUN;
          align_byte <= 1'b0;
          rst_index  <= rst_index + 3'd1;
        end
        default: begin
          phase      <= ST_RUN;
          reset_dc   <= 1'b0;
          align_byte <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/aq_djpeg_mcu_sequencer.sv
// MCU/restart sequencer between the bitstream feeder and Huffman decoder.
// Counts 8x8 blocks within each MCU, reports the component being decoded,
// tracks MCU position, restart handshakes and end of scan.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ProcessInit                    start of scan (highest priority)
//   JpegComp, SubSamplingW/H       component count, luma sampling factors
//   JpegBlockWidth/Height          MCUs per row / MCU rows
//   JpegRestart                    restart interval (0 = disabled)
//   DecodeNextBlock                decoder finished one block
//   DataInEnable / HmInEnable      feeder valid / gated decoder enable
//   DecodeColor, McuX, McuY        current component and MCU position
//   McuDone, ResetDC, DecodeAlignByte, RstIndex, DecodeFinish  status
module aq_djpeg_mcu_sequencer
  import aq_djpeg_pkg::*;
#(
  parameter int COMP_MAX = 4,
  parameter int DIM_W    = 12,
  parameter int RST_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ProcessInit,
  input  logic [2:0]            JpegComp,
  input  logic [1:0]            SubSamplingW,
  input  logic [1:0]            SubSamplingH,
  input  logic [DIM_W-1:0]      JpegBlockWidth,
  input  logic [DIM_W-1:0]      JpegBlockHeight,
  input  logic [RST_W-1:0]      JpegRestart,
  input  logic                  DecodeNextBlock,
  input  logic                  DataInEnable,
  output logic                  HmInEnable,
  output logic [COMP_IDX_W-1:0] DecodeColor,
  output logic [DIM_W-1:0]      McuX,
  output logic [DIM_W-1:0]      McuY,
  output logic                  McuDone,
  output logic                  ResetDC,
  output logic                  DecodeAlignByte,
  output logic [2:0]            RstIndex,
  output logic                  DecodeFinish
);

  logic [2:0]       state;
  logic [3:0]       blk_idx;
  logic [3:0]       blk_nxt;
  logic [3:0]       blk_total;
  logic [3:0]       luma_blocks;
  logic [2:0]       comp_n;
  logic [DIM_W-1:0] x_inc;
  logic [DIM_W-1:0] y_inc;
  logic             last_block;
  logic             last_col;
  logic             last_mcu;
  logic             accept;
  logic             mcu_end;
  logic             gate;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    luma_blocks = {1'b0, sf_decode(SubSamplingW) * sf_decode(SubSamplingH)};
    comp_n      = JpegComp;
    if (JpegComp > 3'(COMP_MAX)) comp_n = 3'(COMP_MAX);
    if (JpegComp == 3'd0)        comp_n = 3'd1;
    // Grayscale scans are non-interleaved: one block per MCU regardless of
    // the sampling factors in the header.
    if (comp_n == 3'd1) blk_total = 4'd1;
    else                blk_total = luma_blocks + {1'b0, comp_n} - 4'd1;
  end

  assign last_block = (blk_idx == blk_total - 4'd1);
  assign blk_nxt    = last_block ? 4'd0 : blk_idx + 4'd1;
  assign x_inc      = McuX + DIM_W'(1);
  assign y_inc      = McuY + DIM_W'(1);
  assign last_col   = (x_inc == JpegBlockWidth);
  assign last_mcu   = last_col && (y_inc == JpegBlockHeight);

  assign accept     = (state == ST_RUN) && gate && DecodeNextBlock && !ProcessInit;
  assign mcu_end    = accept && last_block;
  assign HmInEnable = DataInEnable && (state == ST_RUN) && gate;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      blk_idx      <= '0;
      DecodeColor  <= '0;
      McuX         <= '0;
      McuY         <= '0;
      McuDone      <= 1'b0;
      DecodeFinish <= 1'b0;
    end else if (ProcessInit) begin
      state        <= ST_RUN;
      blk_idx      <= '0;
      DecodeColor  <= '0;
      McuX         <= '0;
      McuY         <= '0;
      McuDone      <= 1'b0;
      DecodeFinish <= 1'b0;
    end else begin
      McuDone <= mcu_end;
      if (accept) begin
        blk_idx <= blk_nxt;
        // Luma blocks come first, then one block per chroma component.
        if (blk_nxt < luma_blocks) DecodeColor <= '0;
        else DecodeColor <= COMP_IDX_W'(blk_nxt - luma_blocks + 4'd1);
        if (last_block) begin
          if (last_col) begin
            McuX <= '0;
            McuY <= y_inc;
          end else begin
            McuX <= x_inc;
          end
          if (last_mcu) begin
            state        <= ST_DONE;
            DecodeFinish <= 1'b1;
          end
        end
      end
    end
  end

  aq_djpeg_restart_ctrl #(
    .RST_W(RST_W)
  ) u_restart_ctrl (
    .clk            (clk),
    .rst            (rst),
    .init           (ProcessInit),
    .mcu_end        (mcu_end),
    .last_mcu       (last_mcu),
    .data_in_enable (DataInEnable),
    .jpeg_restart   (JpegRestart),
    .reset_dc       (ResetDC),
    .align_byte     (DecodeAlignByte),
    .rst_index      (RstIndex),
    .gate           (gate)
  );

endmodule

// File: tb/tb_aq_djpeg_mcu_sequencer.sv
// Self-checking bench for aq_djpeg_mcu_sequencer: table-driven vectors for
// the 4:2:0 and first restart scenarios, hand-written sequences for the
// remaining multi-cycle corner cases.
module tb_aq_djpeg_mcu_sequencer;

  localparam int DIM_W = 12;
  localparam int RST_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ProcessInit = 1'b0;
  logic [2:0]       JpegComp = '0;
  logic [1:0]       SubSamplingW = '0;
  logic [1:0]       SubSamplingH = '0;
  logic [DIM_W-1:0] JpegBlockWidth = '0;
  logic [DIM_W-1:0] JpegBlockHeight = '0;
  logic [RST_W-1:0] JpegRestart = '0;
  logic             DecodeNextBlock = 1'b0;
  logic             DataInEnable = 1'b0;
  logic             HmInEnable;
  logic [2:0]       DecodeColor;
  logic [DIM_W-1:0] McuX;
  logic [DIM_W-1:0] McuY;
  logic             McuDone;
  logic             ResetDC;
  logic             DecodeAlignByte;
  logic [2:0]       RstIndex;
  logic             DecodeFinish;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aq_djpeg_mcu_sequencer #(
    .COMP_MAX(4), .DIM_W(DIM_W), .RST_W(RST_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ProcessInit     (ProcessInit),
    .JpegComp        (JpegComp),
    .SubSamplingW    (SubSamplingW),
    .SubSamplingH    (SubSamplingH),
    .JpegBlockWidth  (JpegBlockWidth),
    .JpegBlockHeight (JpegBlockHeight),
    .JpegRestart     (JpegRestart),
    .DecodeNextBlock (DecodeNextBlock),
    .DataInEnable    (DataInEnable),
    .HmInEnable      (HmInEnable),
    .DecodeColor     (DecodeColor),
    .McuX            (McuX),
    .McuY            (McuY),
    .McuDone         (McuDone),
    .ResetDC         (ResetDC),
    .DecodeAlignByte (DecodeAlignByte),
    .RstIndex        (RstIndex),
    .DecodeFinish    (DecodeFinish)
  );

  // One cycle of stimulus plus expected values. hm is the gated enable
  // before the edge; the rest are the registered outputs after it.
  typedef struct {
    int init; int dnb; int die;
    int hm; int color; int x; int y; int md; int rdc; int al; int ri; int fin;
    int chk_xy;
  } vec_t;

  vec_t t1[$];
  vec_t t2[$];

  function automatic vec_t mk(int init, int dnb, int die, int hm, int color,
                              int x, int y, int md, int rdc, int al, int ri,
                              int fin, int chk_xy);
    vec_t v;
    v.init = init; v.dnb = dnb; v.die = die; v.hm = hm; v.color = color;
    v.x = x; v.y = y; v.md = md; v.rdc = rdc; v.al = al; v.ri = ri;
    v.fin = fin; v.chk_xy = chk_xy;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int comp, input int sw, input int sh,
                         input int w, input int h, input int rs);
    JpegComp        = 3'(comp);
    SubSamplingW    = 2'(sw);
    SubSamplingH    = 2'(sh);
    JpegBlockWidth  = DIM_W'(w);
    JpegBlockHeight = DIM_W'(h);
    JpegRestart     = RST_W'(rs);
  endtask

  task automatic cycle(input int init, input int dnb, input int die);
    ProcessInit     = 1'(init);
    DecodeNextBlock = 1'(dnb);
    DataInEnable    = 1'(die);
    @(posedge clk);
    #1;
    ProcessInit     = 1'b0;
    DecodeNextBlock = 1'b0;
    DataInEnable    = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    ProcessInit     = 1'(v.init);
    DecodeNextBlock = 1'(v.dnb);
    DataInEnable    = 1'(v.die);
    #1;
    check({tag, " hm_en"}, int'(HmInEnable), v.hm);
    @(posedge clk);
    #1;
    check({tag, " color"},  int'(DecodeColor), v.color);
    check({tag, " mcu_done"}, int'(McuDone), v.md);
    check({tag, " reset_dc"}, int'(ResetDC), v.rdc);
    check({tag, " align"},  int'(DecodeAlignByte), v.al);
    check({tag, " rst_idx"}, int'(RstIndex), v.ri);
    check({tag, " finish"}, int'(DecodeFinish), v.fin);
    if (v.chk_xy != 0) begin
      check({tag, " mcu_x"}, int'(McuX), v.x);
      check({tag, " mcu_y"}, int'(McuY), v.y);
    end
    ProcessInit     = 1'b0;
    DecodeNextBlock = 1'b0;
    DataInEnable    = 1'b0;
  endtask

  initial begin
    int exp_ri[9];
    exp_ri = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    // 4:2:0, 3 components, 2x1 MCUs: 6 blocks per MCU (Y Y Y Y Cb Cr).
    //          in  dnb die hm col x y md rdc al ri fin xy
    t1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    t1.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Grayscale 4x2, restart every 3 MCUs.
    t2.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    t2.push_back(mk(0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1));
    t2.push_back(mk(0, 1, 1, 1, 0, 2, 0, 1, 0, 0, 0, 0, 1));
    t2.push_back(mk(0, 1, 1, 1, 0, 3, 0, 1, 1, 0, 0, 0, 1));
    t2.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 1));
    t2.push_back(mk(0, 0, 1, 0, 0, 3, 0, 0, 0, 1, 0, 0, 1));
    t2.push_back(mk(0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 1, 0, 1));
    t2.push_back(mk(0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    DataInEnable = 1'b1;
    #1;
    check("reset hm_en", int'(HmInEnable), 0);
    check("reset outputs", int'({DecodeColor, McuX, McuY, McuDone, ResetDC,
                                 DecodeAlignByte, RstIndex, DecodeFinish}), 0);
    DataInEnable = 1'b0;

    set_cfg(3, 2, 2, 2, 1, 0);
    foreach (t1[i]) apply(t1[i], $sformatf("t420[%0d]", i));

    set_cfg(1, 0, 0, 4, 2, 3);
    foreach (t2[i]) apply(t2[i], $sformatf("rst3[%0d]", i));

    // Restart interval equal to the MCU count: end of scan wins.
    set_cfg(1, 0, 0, 4, 2, 8);
    cycle(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 1);
      check($sformatf("rst8 align[%0d]", i), int'(DecodeAlignByte), 0);
      check($sformatf("rst8 reset_dc[%0d]", i), int'(ResetDC), 0);
    end
    check("rst8 finish", int'(DecodeFinish), 1);
    cycle(0, 0, 1);
    check("rst8 align after", int'(DecodeAlignByte), 0);
    check("rst8 hm_en after", int'(HmInEnable), 0);

    // Restart every MCU: RstIndex walks 1..7 and wraps to 0.
    set_cfg(1, 0, 0, 10, 1, 1);
    cycle(1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cycle(0, 1, 1);
      check($sformatf("rst1 reset_dc[%0d]", i), int'(ResetDC), 1);
      cycle(0, 0, 1);
      check($sformatf("rst1 align[%0d]", i), int'(DecodeAlignByte), 1);
      cycle(0, 0, 0);
      check($sformatf("rst1 align off[%0d]", i), int'(DecodeAlignByte), 0);
      check($sformatf("rst1 rst_idx[%0d]", i), int'(RstIndex), exp_ri[i]);
    end
    cycle(0, 1, 1);
    check("rst1 finish", int'(DecodeFinish), 1);
    check("rst1 reset_dc at end", int'(ResetDC), 0);

    // ProcessInit during PREALIGN with a coincident DecodeNextBlock.
    cycle(1, 0, 0);
    cycle(0, 1, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 1, 1);
    check("pinit pre reset_dc", int'(ResetDC), 1);
    check("pinit pre mcu_x", int'(McuX), 2);
    cycle(1, 1, 0);
    check("pinit mcu_x", int'(McuX), 0);
    check("pinit mcu_y", int'(McuY), 0);
    check("pinit rst_idx", int'(RstIndex), 0);
    check("pinit reset_dc", int'(ResetDC), 0);
    DataInEnable = 1'b1;
    #1;
    check("pinit hm_en", int'(HmInEnable), 1);
    DataInEnable = 1'b0;

    // Synchronous reset while in DONE.
    set_cfg(1, 0, 0, 1, 1, 0);
    cycle(1, 0, 0);
    cycle(0, 1, 1);
    check("rstdone finish", int'(DecodeFinish), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstdone outputs", int'({DecodeColor, McuX, McuY, McuDone, ResetDC,
                                   DecodeAlignByte, RstIndex, DecodeFinish}), 0);
    cycle(0, 1, 1);
    check("rstdone idle mcu_done", int'(McuDone), 0);
    check("rstdone idle finish", int'(DecodeFinish), 0);
    DataInEnable = 1'b1;
    #1;
    check("rstdone idle hm_en", int'(HmInEnable), 0);
    DataInEnable = 1'b0;
    cycle(1, 0, 0);
    DataInEnable = 1'b1;
    #1;
    check("rstdone run hm_en", int'(HmInEnable), 1);
    DataInEnable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aq_djpeg_mcu_sequencer.md
Name: aq_djpeg_mcu_sequencer

Overview:
- Parametrised MCU/restart sequencer between the bitstream feeder and the Huffman decoder.
- Counts 8x8 blocks inside each MCU according to component count and luma sampling factors, and reports the component of the block being decoded.
- Tracks MCU X/Y position, restart intervals, expected RSTn index, DC-predictor reset and byte-alignment handshake.
- Gates the decoder's data-in enable and flags end of scan.

Parameters:
COMP_MAX, 4, maximum components supported (JpegComp values above this clamp to it)
DIM_W, 12, width of MCU X/Y counters and picture-size inputs
RST_W, 16, width of restart interval input and counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ProcessInit  in  1  start of new scan; reinitialises all state
JpegComp  in  3  number of components (1..COMP_MAX)
SubSamplingW  in  2  luma horizontal factor (0/1 -> 1, 2/3 -> 2)
SubSamplingH  in  2  luma vertical factor (same encoding)
JpegBlockWidth  in  DIM_W  MCUs per row
JpegBlockHeight  in  DIM_W  MCU rows
JpegRestart  in  RST_W  restart interval in MCUs; 0 = disabled
DecodeNextBlock  in  1  pulse: decoder finished one 8x8 block
DataInEnable  in  1  feeder word valid
HmInEnable  out  1  gated enable to decoder
DecodeColor  out  3  component index of current block
McuX  out  DIM_W  current MCU column
McuY  out  DIM_W  current MCU row
McuDone  out  1  one-cycle pulse after last block of an MCU
ResetDC  out  1  DC predictors must reset (level)
DecodeAlignByte  out  1  one-cycle pulse: feeder discards to byte boundary / RST marker
RstIndex  out  3  expected RSTn number (mod 8)
DecodeFinish  out  1  scan complete (level)

Behaviour:
- Reset: state IDLE. All counters and outputs are 0.
- IDLE: HmInEnable=0. Only ProcessInit leaves IDLE, going to RUN.
- ProcessInit has highest priority in every state, including same-cycle DecodeNextBlock. It clears block/MCU/restart counters, RstIndex, ResetDC, DecodeAlignByte and DecodeFinish, then enters RUN.
- Blocks per MCU:
  - Y = hf*vf, where hf and vf are the decoded luma factors.
  - Total = Y + min(JpegComp,COMP_MAX) - 1.
  - JpegComp==1 forces total=1.
- DecodeColor:
  - 0 while block index < Y.
  - Otherwise block index - Y + 1.
- RUN:
  - HmInEnable = DataInEnable.
  - On DecodeNextBlock, the block index increments.
  - At the last block of an MCU, the block index wraps to 0, McuDone pulses next cycle, and McuX increments.
  - When McuX+1==JpegBlockWidth, McuX goes to 0 and McuY increments.
- End of scan: last MCU (X+1==W and Y+1==H) goes to DONE. DONE wins over a coincident restart boundary: no align, no ResetDC.
- Restart: when JpegRestart!=0 and the restart count+1==JpegRestart at MCU end, the count goes to 0 and the state goes to PREALIGN. Otherwise the count increments.
- PREALIGN:
  - ResetDC=1 and HmInEnable=0.
  - The first DataInEnable moves to ALIGN.
  - DecodeNextBlock is ignored.
- ALIGN: lasts one cycle with DecodeAlignByte=1 and HmInEnable=0. Then RUN, with RstIndex incremented (7 wraps to 0).
- DONE: DecodeFinish=1, HmInEnable=0, counters frozen until ProcessInit or rst.
- DecodeNextBlock outside RUN is ignored.
- All outputs are registered and update the cycle after the causing event. HmInEnable is combinational from DataInEnable and the registered state.
- JpegBlockWidth/Height=0 is unsupported; counters compare X+1 at DIM_W width.
- Inputs are sampled continuously; software holds them stable between ProcessInit pulses.

Decomposition:
- Package aq_djpeg_pkg holds:
  - state enum (IDLE, RUN, PREALIGN, ALIGN, DONE)
  - sampling-factor decode function
  - component-index width constant
- Sub-module aq_djpeg_restart_ctrl holds the restart counter, RstIndex, and the PREALIGN/ALIGN handshake. Its inputs are McuDone-equivalent and last-MCU. Its outputs are ResetDC, DecodeAlignByte and the gate.

Test Plan:
- 4:2:0, 3 components (W=2,H=2), W=2,H=1, restart 0; 12 DecodeNextBlock pulses -> DecodeColor sequence 0,0,0,0,1,2 twice. McuDone at blocks 6 and 12. DecodeFinish=1 after pulse 12.
- Grayscale, W=4,H=2, restart 3; 3 pulses -> ResetDC=1, HmInEnable=0. Next DataInEnable -> DecodeAlignByte one cycle, RstIndex 0->1, McuX=3. Blocks resume.
- Restart 8, W=4,H=2, grayscale; 8 pulses -> DecodeFinish=1, ResetDC=0, DecodeAlignByte never asserted.
- Restart 1, grayscale, W=10,H=1; 9 MCUs with align handshakes -> RstIndex 1..7,0,1 (wrap after RST7).
- ProcessInit asserted mid-PREALIGN together with DecodeNextBlock -> next cycle state RUN, McuX=McuY=0, RstIndex=0, ResetDC=0.
- rst asserted while in DONE -> next cycle IDLE, all outputs 0. DecodeNextBlock ignored until ProcessInit.
